// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface instruction_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemData;

    modport master (output ImemReq, output ImemAddr, input ImemValid, input ImemData);
    modport slave  (input ImemReq, input ImemAddr, output ImemValid, output ImemData);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage with IF/ID register, one-entry skid buffer and branch redirect/flush.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    instruction_fetch_unit_if.master       imem,
    input  logic                           Stall,
    input  logic                           BranchTaken,
    input  logic [31:0]                    BranchTarget,
    output logic [31:0]                    Instr,
    output logic [31:0]                    InstrPC,
    output logic                           InstrValid,
    output logic [5:0]                     Op,
    output logic [5:0]                     Funct
);
    typedef enum logic [1:0] {S_FETCH, S_DROP, S_SKID} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_drop_addr, w_drop_addr_n;
    logic [31:0] r_instr, w_instr_n;
    logic [31:0] r_instr_pc, w_instr_pc_n;
    logic        r_instr_valid, w_instr_valid_n;
    logic [31:0] r_skid_data, w_skid_data_n;
    logic [31:0] r_skid_pc, w_skid_pc_n;

    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_accept   = ~r_instr_valid | ~Stall;
    assign w_target   = BranchTarget & ~32'd3;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_drop_addr   <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_skid_data   <= '0;
            r_skid_pc     <= '0;
        end else begin
            r_state       <= w_state_n;
            r_pc          <= w_pc_n;
            r_drop_addr   <= w_drop_addr_n;
            r_instr       <= w_instr_n;
            r_instr_pc    <= w_instr_pc_n;
            r_instr_valid <= w_instr_valid_n;
            r_skid_data   <= w_skid_data_n;
            r_skid_pc     <= w_skid_pc_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_pc_n          = r_pc;
        w_drop_addr_n   = r_drop_addr;
        w_instr_n       = r_instr;
        w_instr_pc_n    = r_instr_pc;
        w_instr_valid_n = r_instr_valid;
        w_skid_data_n   = r_skid_data;
        w_skid_pc_n     = r_skid_pc;

        unique case (r_state)
            S_FETCH: begin
                if (BranchTaken) begin
                    w_pc_n = w_target;
                    if (!imem.ImemValid) begin
                        // Request still outstanding: remember its address so it stays stable.
                        w_drop_addr_n = r_pc;
                        w_state_n     = S_DROP;
                    end
                end else if (imem.ImemValid) begin
                    w_pc_n = w_pc_plus4;
                    if (w_accept) begin
                        w_instr_n       = imem.ImemData;
                        w_instr_pc_n    = w_pc_plus4;
                        w_instr_valid_n = 1'b1;
                    end else begin
                        w_skid_data_n = imem.ImemData;
                        w_skid_pc_n   = w_pc_plus4;
                        w_state_n     = S_SKID;
                    end
                end else if (w_accept) begin
                    w_instr_valid_n = 1'b0;
                    w_instr_n       = '0;
                end
            end
            S_DROP: begin
                if (imem.ImemValid) w_state_n = S_FETCH;
                if (BranchTaken)    w_pc_n    = w_target;
            end
            S_SKID: begin
                if (BranchTaken) begin
                    w_pc_n    = w_target;
                    w_state_n = S_FETCH;
                end else if (!Stall) begin
                    w_instr_n       = r_skid_data;
                    w_instr_pc_n    = r_skid_pc;
                    w_instr_valid_n = 1'b1;
                    w_state_n       = S_FETCH;
                end
            end
            default: w_state_n = S_FETCH;
        endcase

        // A redirect flushes IF/ID regardless of state or stall.
        if (BranchTaken) begin
            w_instr_valid_n = 1'b0;
            w_instr_n       = '0;
        end
    end

    always_comb begin
        imem.ImemReq  = ~reset & (r_state != S_SKID);
        imem.ImemAddr = (r_state == S_DROP) ? r_drop_addr : r_pc;
        Instr         = r_instr;
        InstrPC       = r_instr_pc;
        InstrValid    = r_instr_valid;
        Op            = r_instr[31:26];
        Funct         = r_instr[5:0];
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: handshake, stall/skid, redirect, wrap and reset.
module tb_instruction_fetch_unit;
    logic        clk;
    logic        reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic [5:0]  Op;
    logic [5:0]  Funct;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit_if imem ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem.master),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .Op           (Op),
        .Funct        (Funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        imem.ImemValid = 1'b0; imem.ImemData = '0;
        step(); step();
        chk("rst_req",    32'(imem.ImemReq), 32'd0);
        chk("rst_addr",   imem.ImemAddr,     32'h0);
        chk("rst_valid",  32'(InstrValid),   32'd0);
        chk("rst_instr",  Instr,             32'h0);
        chk("rst_ipc",    InstrPC,           32'h0);
        chk("rst_op",     32'(Op),           32'd0);
        chk("rst_funct",  32'(Funct),        32'd0);

        reset = 1'b0;
        #1;
        chk("req_after_rst", 32'(imem.ImemReq), 32'd1);
        imem.ImemValid = 1'b1; imem.ImemData = 32'h8C22_0004;
        step();
        chk("lw_instr", Instr,          32'h8C22_0004);
        chk("lw_op",    32'(Op),        32'h23);
        chk("lw_funct", 32'(Funct),     32'h04);
        chk("lw_ipc",   InstrPC,        32'h4);
        chk("lw_valid", 32'(InstrValid), 32'd1);
        chk("lw_next",  imem.ImemAddr,  32'h4);

        // Back-to-back stream, one word per cycle
        for (int k = 0; k < 4; k++) begin
            imem.ImemData = 32'h0000_1000 + 32'(k);
            step();
            chk("stream_ipc",   InstrPC,          32'(8 + 4 * k));
            chk("stream_valid", 32'(InstrValid),  32'd1);
            chk("stream_instr", Instr,            32'h0000_1000 + 32'(k));
        end

        // Stall with IF/ID full: response goes to skid
        Stall = 1'b1; imem.ImemData = 32'hABCD_0001;
        step();
        imem.ImemValid = 1'b0;
        chk("skid_req",   32'(imem.ImemReq), 32'd0);
        chk("skid_hold",  Instr,             32'h0000_1003);
        chk("skid_hpc",   InstrPC,           32'd20);
        step();
        chk("skid_req2",  32'(imem.ImemReq), 32'd0);
        chk("skid_hold2", Instr,             32'h0000_1003);
        Stall = 1'b0;
        step();
        chk("unskid_instr", Instr,             32'hABCD_0001);
        chk("unskid_ipc",   InstrPC,           32'd24);
        chk("unskid_valid", 32'(InstrValid),   32'd1);
        chk("unskid_req",   32'(imem.ImemReq), 32'd1);
        chk("unskid_addr",  imem.ImemAddr,     32'd24);

        // Bubble empties IF/ID
        step();
        chk("bubble_valid", 32'(InstrValid), 32'd0);
        chk("bubble_instr", Instr,           32'h0);

        // Redirect while request to 24 is outstanding
        BranchTaken = 1'b1; BranchTarget = 32'h43;
        step();
        BranchTaken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drop_addr",  imem.ImemAddr,     32'd24);
            chk("drop_req",   32'(imem.ImemReq), 32'd1);
            chk("drop_valid", 32'(InstrValid),   32'd0);
            step();
        end
        imem.ImemValid = 1'b1; imem.ImemData = 32'hDEAD_BEEF;
        step();
        imem.ImemValid = 1'b0;
        chk("redir_addr",  imem.ImemAddr,   32'h40);
        chk("redir_valid", 32'(InstrValid), 32'd0);
        chk("redir_instr", Instr,           32'h0);

        // Fill IF/ID, then branch + stall together
        imem.ImemValid = 1'b1; imem.ImemData = 32'h0000_0020;
        step();
        chk("fill_instr", Instr,   32'h0000_0020);
        chk("fill_ipc",   InstrPC, 32'h44);
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h100; imem.ImemData = 32'h1111_1111;
        step();
        Stall = 1'b0; BranchTaken = 1'b0;
        chk("bs_valid", 32'(InstrValid), 32'd0);
        chk("bs_instr", Instr,           32'h0);
        chk("bs_addr",  imem.ImemAddr,   32'h100);

        // PC wrap at top of address space
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        step();
        BranchTaken = 1'b0;
        chk("wrap_pre", imem.ImemAddr, 32'hFFFF_FFFC);
        imem.ImemData = 32'h2222_2222;
        step();
        chk("wrap_addr",  imem.ImemAddr, 32'h0);
        chk("wrap_ipc",   InstrPC,       32'h0);
        chk("wrap_instr", Instr,         32'h2222_2222);

        // Redirect in DROP coinciding with the dropped response
        imem.ImemValid = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h200;
        step();
        chk("d2_addr", imem.ImemAddr, 32'h0);
        imem.ImemValid = 1'b1; imem.ImemData = 32'h3333_3333; BranchTarget = 32'h300;
        step();
        BranchTaken = 1'b0;
        chk("d2_redir", imem.ImemAddr,   32'h300);
        chk("d2_valid", 32'(InstrValid), 32'd0);

        // Reset while in SKID abandons skid content
        imem.ImemData = 32'h4444_4444;
        step();
        chk("r_fill", Instr, 32'h4444_4444);
        Stall = 1'b1; imem.ImemData = 32'h5555_5555;
        step();
        chk("r_skid_req", 32'(imem.ImemReq), 32'd0);
        imem.ImemValid = 1'b0; reset = 1'b1; Stall = 1'b0;
        step();
        chk("rs_valid", 32'(InstrValid),   32'd0);
        chk("rs_instr", Instr,             32'h0);
        chk("rs_addr",  imem.ImemAddr,     32'h0);
        chk("rs_req",   32'(imem.ImemReq), 32'd0);
        reset = 1'b0;
        step();
        chk("rs2_valid", 32'(InstrValid),   32'd0);
        chk("rs2_instr", Instr,             32'h0);
        chk("rs2_req",   32'(imem.ImemReq), 32'd1);
        chk("rs2_addr",  imem.ImemAddr,     32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
